// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder.
//   fmt_e      : instruction format codes (CSR, I, S, U, J, B); codes 6-7 are illegal.
//   *_LSB/*_MSB: instruction-word bit positions of every immediate field.
//   fmt_legal(): true for the six defined format codes.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_CSR = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_B   = 3'd5
    } fmt_e;

    // CSR zimm lives in the rs1 slot.
    localparam int CSR_LSB   = 15;
    localparam int CSR_MSB   = 19;
    // I-type immediate.
    localparam int I_LSB     = 20;
    localparam int I_MSB     = 31;
    // S-type: high part over funct7, low part over rd.
    localparam int S_HI_LSB  = 25;
    localparam int S_HI_MSB  = 31;
    localparam int S_LO_LSB  = 7;
    localparam int S_LO_MSB  = 11;
    // U-type upper immediate.
    localparam int U_LSB     = 12;
    localparam int U_MSB     = 31;
    // J-type scrambled fields.
    localparam int J_B20_POS = 31;
    localparam int J_LO_LSB  = 21;
    localparam int J_LO_MSB  = 30;
    localparam int J_B11_POS = 20;
    localparam int J_HI_LSB  = 12;
    localparam int J_HI_MSB  = 19;
    // B-type scrambled fields.
    localparam int B_B12_POS = 31;
    localparam int B_HI_LSB  = 25;
    localparam int B_HI_MSB  = 30;
    localparam int B_LO_LSB  = 8;
    localparam int B_LO_MSB  = 11;
    localparam int B_B11_POS = 7;

    function automatic logic fmt_legal(input logic [2:0] fmt);
        return fmt <= 3'(FMT_B);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: the exact inverse of the zero-extending
// immediate decode. Places the in-field bits of imm into an otherwise-zero
// instruction word and flags values the format cannot represent.
//   fmt   : format code (see imm_pkg::fmt_e)
//   imm   : immediate value
//   instr : packed instruction word (in-field bits only; zero for illegal fmt)
//   err   : out-of-field bits set, or illegal fmt
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        instr = '0;
        err   = 1'b0;
        if (!fmt_legal(fmt)) begin
            err = 1'b1;
        end else begin
            case (fmt_e'(fmt))
                FMT_CSR: begin
                    instr[CSR_MSB:CSR_LSB] = imm[4:0];
                    err                    = |imm[31:5];
                end
                FMT_I: begin
                    instr[I_MSB:I_LSB] = imm[11:0];
                    err                = |imm[31:12];
                end
                FMT_S: begin
                    instr[S_HI_MSB:S_HI_LSB] = imm[11:5];
                    instr[S_LO_MSB:S_LO_LSB] = imm[4:0];
                    err                      = |imm[31:12];
                end
                FMT_U: begin
                    instr[U_MSB:U_LSB] = imm[31:12];
                    err                = |imm[11:0];
                end
                FMT_J: begin
                    instr[J_B20_POS]         = imm[20];
                    instr[J_LO_MSB:J_LO_LSB] = imm[10:1];
                    instr[J_B11_POS]         = imm[11];
                    instr[J_HI_MSB:J_HI_LSB] = imm[19:12];
                    err                      = (|imm[31:21]) | imm[0];
                end
                FMT_B: begin
                    instr[B_B12_POS]         = imm[12];
                    instr[B_HI_MSB:B_HI_LSB] = imm[10:5];
                    instr[B_LO_MSB:B_LO_LSB] = imm[4:1];
                    instr[B_B11_POS]         = imm[11];
                    err                      = (|imm[31:13]) | imm[0];
                end
                default: begin
                    instr = '0;
                    err   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage elastic immediate encoder.
//   S1 registers the request (fmt, imm); S2 registers the packed result.
//   Valid/ready handshake on both sides; one result per cycle when unstalled.
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   in_valid/in_ready       : request handshake
//   in_fmt, in_imm          : format code and immediate to encode
//   out_valid/out_ready     : result handshake
//   out_instr, out_fmt      : packed instruction word and its format code
//   out_err                 : value not representable, or illegal format
//   err_cnt, err_cnt_clr    : saturating error-transfer counter and its clear;
//                             present only when IMM_ENCODER_ERR_CNT_EN is defined
module imm_encoder
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_fmt,
`ifdef IMM_ENCODER_ERR_CNT_EN
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr
`else
    output logic             out_err
`endif
);

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [31:0] s1_imm;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic        s2_err;
    logic [2:0]  s2_fmt;

    logic [31:0] pack_instr;
    logic        pack_err;
    logic        s2_ready;

    // A stage can take new data when empty or when its contents leave this cycle.
    assign s2_ready = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    imm_pack u_pack (
        .fmt   (s1_fmt),
        .imm   (s1_imm),
        .instr (pack_instr),
        .err   (pack_err)
    );

    // NOTE: the data registers are reset too, because the result outputs must read zero during reset.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_fmt   <= '0;
            s1_imm   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt <= in_fmt;
                s1_imm <= in_imm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
            s2_fmt   <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= pack_instr;
                s2_err   <= pack_err;
                s2_fmt   <= s1_fmt;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;
    assign out_fmt   = s2_fmt;

`ifdef IMM_ENCODER_ERR_CNT_EN
    // Clear wins over a coincident error transfer; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_cnt_clr) begin
            err_cnt <= '0;
        end else if (s2_valid && out_ready && s2_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: single-request latency/packing vectors,
// a back-to-back stream under a stalling consumer, mid-operation reset, and
// (when IMM_ENCODER_ERR_CNT_EN is defined) the saturating error counter.
module tb_imm_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [2:0]       out_fmt;
    logic             out_err;
    logic             err_cnt_clr;
`ifdef IMM_ENCODER_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fmt      (in_fmt),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_fmt     (out_fmt),
`ifdef IMM_ENCODER_ERR_CNT_EN
        .out_err     (out_err),
        .err_cnt     (err_cnt),
        .err_cnt_clr (err_cnt_clr)
`else
        .out_err     (out_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Hand-computed directed vectors.
    localparam int NV = 10;
    logic [2:0]  v_fmt   [NV];
    logic [31:0] v_imm   [NV];
    logic [31:0] v_instr [NV];
    logic        v_err   [NV];

    initial begin
        v_fmt[0] = 3'd1; v_imm[0] = 32'h0000_07FF; v_instr[0] = 32'h7FF0_0000; v_err[0] = 1'b0;
        v_fmt[1] = 3'd2; v_imm[1] = 32'h0000_0123; v_instr[1] = 32'h1200_0180; v_err[1] = 1'b0;
        v_fmt[2] = 3'd3; v_imm[2] = 32'h1234_5000; v_instr[2] = 32'h1234_5000; v_err[2] = 1'b0;
        v_fmt[3] = 3'd3; v_imm[3] = 32'h1234_5678; v_instr[3] = 32'h1234_5000; v_err[3] = 1'b1;
        v_fmt[4] = 3'd4; v_imm[4] = 32'h000F_FFFE; v_instr[4] = 32'h7FFF_F000; v_err[4] = 1'b0;
        v_fmt[5] = 3'd5; v_imm[5] = 32'h0000_1000; v_instr[5] = 32'h8000_0000; v_err[5] = 1'b0;
        v_fmt[6] = 3'd5; v_imm[6] = 32'h0000_0801; v_instr[6] = 32'h0000_0080; v_err[6] = 1'b1;
        v_fmt[7] = 3'd7; v_imm[7] = 32'h0000_0001; v_instr[7] = 32'h0000_0000; v_err[7] = 1'b1;
        v_fmt[8] = 3'd0; v_imm[8] = 32'h0000_001F; v_instr[8] = 32'h000F_8000; v_err[8] = 1'b0;
        v_fmt[9] = 3'd0; v_imm[9] = 32'h0000_0021; v_instr[9] = 32'h0000_8000; v_err[9] = 1'b1;
    end

    // One request into an empty pipe: accepted at edge N, visible after N+1,
    // taken at N+2. Optionally pulses err_cnt_clr on the transfer edge.
    task automatic send_one(input int i, input logic clr_at_xfer);
        string tag;
        tag = $sformatf("v%0d", i);
        @(negedge clk);
        in_valid  = 1'b1;
        in_fmt    = v_fmt[i];
        in_imm    = v_imm[i];
        out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({tag, "_valid_n"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid_n1"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, v_instr[i]);
        check({tag, "_err"}, 32'(out_err), 32'(v_err[i]));
        check({tag, "_fmt"}, 32'(out_fmt), 32'(v_fmt[i]));
        err_cnt_clr = clr_at_xfer;
        @(posedge clk);
        #1 err_cnt_clr = 1'b0;
        check({tag, "_valid_n2"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int sent, got, occ, exp_q[$];
        logic [3:0] rdy_pat;
        rdy_pat     = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 3 first)
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_fmt      = '0;
        in_imm      = '0;
        out_ready   = 1'b0;
        err_cnt_clr = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_fmt", 32'(out_fmt), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
`ifdef IMM_ENCODER_ERR_CNT_EN
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single-request vectors.
        for (int i = 0; i < NV; i++) send_one(i, 1'b0);

        // Back-to-back stream with a stalling consumer.
        sent = 0; got = 0; occ = 0;
        for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
            logic acc, dlv;
            @(negedge clk);
            out_ready = rdy_pat[3 - (cyc % 4)];
            in_valid  = (sent < 8);
            in_fmt    = v_fmt[sent % NV];
            in_imm    = v_imm[sent % NV];
            #1;
            check($sformatf("str_in_ready_c%0d", cyc), 32'(in_ready),
                  32'((occ < 2) || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("str_spurious_c%0d", cyc), 32'(out_valid), 32'd0);
                end else begin
                    check($sformatf("str_instr_c%0d", cyc), out_instr, v_instr[exp_q[0]]);
                    check($sformatf("str_err_c%0d", cyc), 32'(out_err), 32'(v_err[exp_q[0]]));
                end
            end
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            if (acc) begin
                exp_q.push_back(sent % NV);
                sent++;
            end
            if (dlv && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            occ = occ + int'(acc) - int'(dlv);
        end
        @(negedge clk) in_valid = 1'b0;
        check("str_delivered", 32'(got), 32'd8);

        // Mid-operation reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_fmt    = v_fmt[0];
        in_imm    = v_imm[0];
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_instr", out_instr, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1 check($sformatf("midrst_stale_c%0d", c), 32'(out_valid), 32'd0);
        end

`ifdef IMM_ENCODER_ERR_CNT_EN
        // Three error transfers, then one coincident with clear.
        send_one(3, 1'b0);
        send_one(6, 1'b0);
        send_one(7, 1'b0);
        check("err_cnt_3", 32'(err_cnt), 32'd3);
        send_one(9, 1'b1);
        check("err_cnt_clr_prio", 32'(err_cnt), 32'd0);
        send_one(0, 1'b0);
        check("err_cnt_no_err", 32'(err_cnt), 32'd0);
        send_one(3, 1'b0);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
